// File: rtl/dco_freq_tracker.sv
// dco_freq_tracker: closed-loop frequency controller for the ring-oscillator DCO.
// Counts synchronised osc_i rising edges over a fixed clk_i window and steps
// freq_sel_o toward target_cnt_i until the count stays inside a deadband.
// Optional feature macro: DCO_TRACK_BINSEARCH_EN (binary-search first acquisition).
module dco_freq_tracker #(
    parameter int unsigned CTRL_WIDTH    = 4,
    parameter int unsigned CNT_WIDTH     = 12,
    parameter int unsigned GATE_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DEADBAND      = 2,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned INIT_SEL      = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  osc_i,
    input  logic [CNT_WIDTH-1:0]  target_cnt_i,
    output logic                  osc_en_o,
    output logic [CTRL_WIDTH-1:0] freq_sel_o,
    output logic [CNT_WIDTH-1:0]  meas_cnt_o,
    output logic                  meas_valid_o,
    output logic                  locked_o
);

    localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam int unsigned LOCK_W  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned CMP_W   = CNT_WIDTH + 2;

    localparam logic [CTRL_WIDTH-1:0] SEL_MAX  = {CTRL_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [TMR_W-1:0]      SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]      GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [LOCK_W-1:0]     LOCK_TGT    = LOCK_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic                  osc_sync1;
    logic                  osc_sync2;
    logic                  osc_sync3;
    logic                  osc_rise_c;

    logic [TMR_W-1:0]      timer_q;
    logic [CNT_WIDTH-1:0]  edge_cnt_q;
    logic [LOCK_W-1:0]     lock_cnt_q;
    logic [LOCK_W-1:0]     lock_cnt_d;

    logic                  osc_en_d;
    logic [CTRL_WIDTH-1:0] freq_sel_d;
    logic [CNT_WIDTH-1:0]  meas_cnt_d;
    logic                  meas_valid_d;
    logic                  locked_d;

    logic [CTRL_WIDTH-1:0] step_c;
    logic [CTRL_WIDTH:0]   sum_up_c;
    logic [CTRL_WIDTH-1:0] sel_up_c;
    logic [CTRL_WIDTH-1:0] sel_dn_c;

    logic signed [CMP_W-1:0] meas_s;
    logic signed [CMP_W-1:0] lo_s;
    logic signed [CMP_W-1:0] hi_s;
    logic                    below_c;
    logic                    above_c;
    logic                    in_band_c;
    logic                    code_chg_c;

`ifdef DCO_TRACK_BINSEARCH_EN
    localparam logic [CTRL_WIDTH-1:0] STEP_MAX = CTRL_WIDTH'(2 ** (CTRL_WIDTH - 1));
    logic [CTRL_WIDTH-1:0] step_q;
    logic [CTRL_WIDTH-1:0] step_d;
    assign step_c = step_q;
`else
    assign step_c = CTRL_WIDTH'(1);
`endif

    // Two-flop synchroniser plus history flop for rising-edge detection of osc_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            osc_sync1 <= 1'b0;
            osc_sync2 <= 1'b0;
            osc_sync3 <= 1'b0;
        end else begin
            osc_sync1 <= osc_i;
            osc_sync2 <= osc_sync1;
            osc_sync3 <= osc_sync2;
        end
    end

    assign osc_rise_c = osc_sync2 & ~osc_sync3;

    // Window count vs target, widened and signed so target +/- deadband cannot wrap
    assign meas_s    = $signed({2'b00, edge_cnt_q});
    assign lo_s      = $signed({2'b00, target_cnt_i}) - $signed(CMP_W'(DEADBAND));
    assign hi_s      = $signed({2'b00, target_cnt_i}) + $signed(CMP_W'(DEADBAND));
    assign below_c   = (meas_s < lo_s);
    assign above_c   = (meas_s > hi_s);
    assign in_band_c = ~below_c & ~above_c;

    // Saturating candidate codes; a change only happens when not already pinned
    assign sum_up_c   = {1'b0, freq_sel_o} + {1'b0, step_c};
    assign sel_up_c   = sum_up_c[CTRL_WIDTH] ? SEL_MAX : sum_up_c[CTRL_WIDTH-1:0];
    assign sel_dn_c   = (freq_sel_o < step_c) ? '0 : (freq_sel_o - step_c);
    assign code_chg_c = (below_c && (freq_sel_o != SEL_MAX)) ||
                        (above_c && (freq_sel_o != '0));

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; enable_i low forces IDLE from any state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = SETTLE;
            end
            SETTLE: begin
                if (!enable_i)                  state_d = IDLE;
                else if (timer_q == SETTLE_LAST) state_d = MEASURE;
            end
            MEASURE: begin
                if (!enable_i)                state_d = IDLE;
                else if (timer_q == GATE_LAST) state_d = UPDATE;
            end
            UPDATE: begin
                if (!enable_i)       state_d = IDLE;
                else if (code_chg_c) state_d = SETTLE;
                else                 state_d = MEASURE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase timer and saturating window edge counter, both restarted on state entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q    <= '0;
            edge_cnt_q <= '0;
        end else begin
            if ((state_d == IDLE) || (state_d != state_q)) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TMR_W'(1);
            end

            if (state_d == IDLE) begin
                edge_cnt_q <= '0;
            end else if ((state_d == MEASURE) && (state_q != MEASURE)) begin
                edge_cnt_q <= '0;
            end else if ((state_q == MEASURE) && osc_rise_c && (edge_cnt_q != CNT_MAX)) begin
                edge_cnt_q <= edge_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // FSM output logic: next values of the registered outputs and lock tracking
    always_comb begin
        osc_en_d     = (state_d != IDLE);
        freq_sel_d   = freq_sel_o;
        meas_cnt_d   = meas_cnt_o;
        meas_valid_d = 1'b0;
        locked_d     = locked_o;
        lock_cnt_d   = lock_cnt_q;
`ifdef DCO_TRACK_BINSEARCH_EN
        step_d       = step_q;
`endif
        if (state_d == IDLE) begin
            locked_d   = 1'b0;
            lock_cnt_d = '0;
        end else if (state_q == UPDATE) begin
            meas_cnt_d   = edge_cnt_q;
            meas_valid_d = 1'b1;
            if (in_band_c) begin
                lock_cnt_d = (lock_cnt_q == LOCK_TGT) ? lock_cnt_q : (lock_cnt_q + LOCK_W'(1));
                locked_d   = (lock_cnt_d == LOCK_TGT);
            end else begin
                lock_cnt_d = '0;
                locked_d   = 1'b0;
                if (below_c) freq_sel_d = sel_up_c;
                if (above_c) freq_sel_d = sel_dn_c;
`ifdef DCO_TRACK_BINSEARCH_EN
                if (step_q > CTRL_WIDTH'(1)) step_d = step_q >> 1;
`endif
            end
        end
`ifdef DCO_TRACK_BINSEARCH_EN
        if ((state_q == IDLE) && (state_d == SETTLE)) begin
            step_d = STEP_MAX;
        end
`endif
    end

    // Output and loop-status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            osc_en_o     <= 1'b0;
            freq_sel_o   <= CTRL_WIDTH'(INIT_SEL);
            meas_cnt_o   <= '0;
            meas_valid_o <= 1'b0;
            locked_o     <= 1'b0;
            lock_cnt_q   <= '0;
        end else begin
            osc_en_o     <= osc_en_d;
            freq_sel_o   <= freq_sel_d;
            meas_cnt_o   <= meas_cnt_d;
            meas_valid_o <= meas_valid_d;
            locked_o     <= locked_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

`ifdef DCO_TRACK_BINSEARCH_EN
    // Acquisition step size, reloaded to half-scale on every IDLE exit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_q <= STEP_MAX;
        end else begin
            step_q <= step_d;
        end
    end
`endif

endmodule

// File: tb/tb_dco_freq_tracker.sv
// tb_dco_freq_tracker: directed bench for dco_freq_tracker with a behavioural DCO model.
// The DCO model produces exactly rate(mode, freq_sel) rising edges in any 64-cycle span.
module tb_dco_freq_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        osc = 1'b0;
    logic [11:0] target = '0;
    logic        osc_en;
    logic [3:0]  freq_sel;
    logic [11:0] meas_cnt;
    logic        meas_valid;
    logic        locked;

    int vectors = 0;
    int miscompares = 0;
    int mode = 0;
    int acc = 0;

    always #5 clk = ~clk;

    dco_freq_tracker #(
        .CTRL_WIDTH   (4),
        .CNT_WIDTH    (12),
        .GATE_CYCLES  (64),
        .SETTLE_CYCLES(4),
        .DEADBAND     (1),
        .LOCK_COUNT   (4),
        .INIT_SEL     (0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .osc_i        (osc),
        .target_cnt_i (target),
        .osc_en_o     (osc_en),
        .freq_sel_o   (freq_sel),
        .meas_cnt_o   (meas_cnt),
        .meas_valid_o (meas_valid),
        .locked_o     (locked)
    );

    // Edges per 64-cycle window for each DCO model
    function automatic int rate(input int m, input int s);
        case (m)
            0:       return 8;
            1:       return 4 + 2 * s;
            default: return 2 + s;
        endcase
    endfunction

    // DCO model: phase accumulator mod 64, output high in the upper half
    always @(negedge clk) begin
        if (rst || !osc_en) begin
            acc = 0;
            osc = 1'b0;
        end else begin
            acc = (acc + rate(mode, int'(freq_sel))) % 64;
            osc = (acc >= 32);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a meas_valid pulse and check the reported window
    task automatic expect_pulse(input string tag, input int exp_lat, input int exp_meas,
                                input int exp_sel, input int exp_lock);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (meas_valid === 1'b1) seen = 1'b1;
        end
        check({tag, " pulse_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            if (exp_lat > 0) check({tag, " latency"}, 32'(n), 32'(exp_lat));
            check({tag, " meas_cnt"}, 32'(meas_cnt), 32'(exp_meas));
            check({tag, " freq_sel"}, 32'(freq_sel), 32'(exp_sel));
            check({tag, " locked"},   32'(locked),   32'(exp_lock));
        end
    endtask

    int s3_meas [9];
    int s3_sel  [9];
    int s3_lock [9];
    int s4_meas [12];
    int s4_sel  [12];

    initial begin
        bit en_seen;
        bit v_seen;

`ifdef DCO_TRACK_BINSEARCH_EN
        s3_meas = '{4, 20, 12, 16, 14, 14, 14, 14, 14};
        s3_sel  = '{8, 4, 6, 5, 5, 5, 5, 5, 5};
        s3_lock = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        s4_meas = '{7, 15, 17, 17, 17, 17, 17, 17, 17, 17, 17, 17};
        s4_sel  = '{13, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15};
`else
        s3_meas = '{4, 6, 8, 10, 12, 14, 14, 14, 14};
        s3_sel  = '{1, 2, 3, 4, 5, 5, 5, 5, 5};
        s3_lock = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        s4_meas = '{7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 17};
        s4_sel  = '{6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 15, 15};
`endif

        // Reset values, then idle with enable low
        repeat (3) tick();
        check("rst osc_en",     32'(osc_en),     32'd0);
        check("rst freq_sel",   32'(freq_sel),   32'd0);
        check("rst meas_cnt",   32'(meas_cnt),   32'd0);
        check("rst meas_valid", 32'(meas_valid), 32'd0);
        check("rst locked",     32'(locked),     32'd0);
        rst = 1'b0;
        en_seen = 1'b0;
        v_seen  = 1'b0;
        repeat (100) begin
            tick();
            if (osc_en !== 1'b0)     en_seen = 1'b1;
            if (meas_valid !== 1'b0) v_seen  = 1'b1;
        end
        check("idle osc_en_seen", 32'(en_seen), 32'd0);
        check("idle valid_seen",  32'(v_seen),  32'd0);

        // Fixed 8-edge DCO, target 8: in-band every window, lock on 4th pulse
        mode   = 0;
        target = 12'd8;
        enable = 1'b1;
        expect_pulse("s2 w1", 70, 8, 0, 0);
        tick();
        check("s2 valid_one_cycle", 32'(meas_valid), 32'd0);
        check("s2 osc_en", 32'(osc_en), 32'd1);
        expect_pulse("s2 w2", 0, 8, 0, 0);
        expect_pulse("s2 w3", 0, 8, 0, 0);
        expect_pulse("s2 w4", 0, 8, 0, 1);

        enable = 1'b0;
        tick();
        check("s2 dis osc_en", 32'(osc_en), 32'd0);
        check("s2 dis locked", 32'(locked), 32'd0);

        // Linear DCO 4+2*sel, target 14: walk up to code 5 and lock
        mode   = 1;
        target = 12'd14;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            expect_pulse($sformatf("s3 w%0d", i + 1), (i == 0) ? 70 : 0,
                         s3_meas[i], s3_sel[i], s3_lock[i]);
        end

        // Drop enable mid-window: window discarded, code and count kept
        repeat (20) tick();
        enable = 1'b0;
        tick();
        check("s5 osc_en",   32'(osc_en),   32'd0);
        check("s5 locked",   32'(locked),   32'd0);
        check("s5 freq_sel", 32'(freq_sel), 32'd5);
        check("s5 meas_cnt", 32'(meas_cnt), 32'd14);
        en_seen = 1'b0;
        v_seen  = 1'b0;
        repeat (100) begin
            tick();
            if (osc_en !== 1'b0)     en_seen = 1'b1;
            if (meas_valid !== 1'b0) v_seen  = 1'b1;
        end
        check("s5 osc_en_seen", 32'(en_seen), 32'd0);
        check("s5 valid_seen",  32'(v_seen),  32'd0);
        enable = 1'b1;
        expect_pulse("s5 resume", 70, 14, 5, 0);

        // Unreachable target: code climbs to 15 and pins there without wrapping
        enable = 1'b0;
        tick();
        mode   = 2;
        target = 12'd4095;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            expect_pulse($sformatf("s4 w%0d", i + 1), (i == 0) ? 70 : 0,
                         s4_meas[i], s4_sel[i], 0);
        end

        // Asynchronous reset mid-window returns everything to reset values
        repeat (30) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst osc_en",     32'(osc_en),     32'd0);
        check("arst freq_sel",   32'(freq_sel),   32'd0);
        check("arst meas_cnt",   32'(meas_cnt),   32'd0);
        check("arst meas_valid", 32'(meas_valid), 32'd0);
        check("arst locked",     32'(locked),     32'd0);
        v_seen = 1'b0;
        repeat (5) begin
            tick();
            if (meas_valid !== 1'b0) v_seen = 1'b1;
        end
        check("arst valid_seen", 32'(v_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
